regfile_param_clr: RTL and testbench
====================================

// Module: regfile_param_clr
// PURPOSE
//   Parametrised N-read/1-write register file for the multi-cycle RV32 core, successor to the fixed 32x32 file.
//   Adds configurable width, depth and read-port count, optional write-to-read bypass and an optional hardwired-zero
//   register. Contents are cleared by a sequential clear engine (one entry per clock), so the array maps to RAM.
//   The engine runs automatically after reset and on request. Sits between decode (read) and writeback (write).
// PARAMETERS
//   XLEN      32  data width of each register
//   NREGS     32  number of registers; power of two, >=2
//   NRD       2   number of combinational read ports, >=1
//   ZERO_REG  1   1: register 0 always reads 0 and writes to it are discarded
//   BYPASS    1   1: a same-cycle accepted write is forwarded to matching read ports
//   AW        localparam = $clog2(NREGS), register address width
// PORTS
//   clk       in   1          clock, rising edge
//   reset_n   in   1          asynchronous, active-low reset
//   we        in   1          write enable; register wa is written with wd on the rising edge
//   wa        in   AW         write address
//   wd        in   XLEN       write data
//   ra        in   NRD*AW     read addresses; port i = ra[i*AW +: AW]
//   rd        out  NRD*XLEN   read data; port i = rd[i*XLEN +: XLEN], combinational
//   clr_req   in   1          start (or restart) a full clear; sampled in any state
//   clr_busy  out  1          clear engine active; writes are not accepted
//   clr_done  out  1          one-cycle pulse after the last entry is cleared
//   wr_drop   out  1          registered pulse: a write was presented while clr_busy=1 and discarded
// BEHAVIOUR
//   Reset (reset_n=0, async): state=CLEAR, clr_ptr=0, clr_busy=1, clr_done=0, wr_drop=0. The array is not reset directly.
//   FSM states:
//     CLEAR: each clock writes mem[clr_ptr]<=0 and increments clr_ptr.
//            When clr_ptr==NREGS-1: go to IDLE, clr_busy<=0, clr_done<=1 for one cycle.
//     IDLE:  clr_req=1 -> CLEAR with clr_ptr<=0 and clr_busy<=1.
//   Clear timing: exactly NREGS cycles in CLEAR. The first IDLE cycle is the clr_done cycle.
//   clr_req in CLEAR restarts the clear (clr_ptr<=0); clr_done does not fire for the aborted pass.
//   clr_req in the same cycle as the final clear step also restarts; no clr_done.
//   Write accept = we & ~clr_busy & ~(ZERO_REG & wa==0). An accepted write updates mem[wa] on the rising edge.
//   we=1 with clr_busy=1 -> write discarded, wr_drop=1 on the next cycle. wr_drop is otherwise 0.
//   A write to reg 0 with ZERO_REG=1 is discarded silently (no wr_drop).
//   Read port i, combinational, priority order:
//     1. ZERO_REG and ra_i==0 -> 0.
//     2. BYPASS and write accepted and wa==ra_i -> wd.
//     3. Otherwise mem[ra_i].
//   Reads during CLEAR return the array contents: 0 for entries below clr_ptr, old or undefined data at or above it.
//   Consumers gate on clr_busy.
//   Ports are independent; any number of read ports may address the same register.
//   Reset asserted mid-clear or mid-write aborts the operation; the clear restarts at entry 0 after reset_n rises.
//   No arithmetic beyond clr_ptr increment (AW bits). The terminal compare prevents wrap.
// TESTING
//   1. Reset, then release: clr_busy=1 for 32 cycles, clr_done pulses once, every register reads 0 on all ports.
//   2. After clear: write x5=0xDEADBEEF, then read port0=5, port1=5 next cycle -> both 0xDEADBEEF.
//      With BYPASS=1, the same-cycle read also returns 0xDEADBEEF; with BYPASS=0 it returns 0.
//   3. Write x0=0x12345678 with ZERO_REG=1: rd on x0 is 0 in the same and later cycles; wr_drop stays 0.
//   4. clr_req in IDLE with x7=0xA5A5A5A5 loaded: we=1 wa=3 during CLEAR -> wr_drop pulse, x3 stays 0.
//      Done after 32 cycles, x7=0.
//   5. clr_req asserted again at clr_ptr=10: clear restarts at 0, busy for 32 more cycles, a single clr_done.
//   6. reset_n pulsed low at clr_ptr=20 and during an accepted write: clr_busy stays 1 and the clear restarts.
//      Repeat with NREGS=16, NRD=3, XLEN=64: 16-cycle clear, three ports read independently.

Source files
------------

// File: rtl/regfile_param_clr.sv
// rtl/regfile_param_clr.sv - parametrised N-read/1-write register file with sequential clear engine
// The array has no reset so it can map to RAM; the clear engine zeroes one entry per clock.
module regfile_param_clr #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done,
  output logic                wr_drop
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
  logic            clr_done_q, clr_done_d;
  logic            wr_drop_q, wr_drop_d;
  logic            wr_acc;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;
  logic [XLEN-1:0] mem_q [NREGS];

  assign clr_busy = (state_q == S_CLEAR);
  assign clr_done = clr_done_q;
  assign wr_drop  = wr_drop_q;
  assign wr_acc   = we && !clr_busy && !(ZERO_REG && (wa == '0));

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    clr_done_d = 1'b0;
    wr_drop_d  = we && clr_busy;
    case (state_q)
      S_CLEAR: begin
        // a request on the final step restarts too, so it wins over completion
        if (clr_req) begin
          clr_ptr_d = '0;
        end else if (clr_ptr_q == AW'(NREGS - 1)) begin
          state_d    = S_IDLE;
          clr_ptr_d  = '0;
          clr_done_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      default: begin
        if (clr_req) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_CLEAR;
      clr_ptr_q  <= '0;
      clr_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      clr_done_q <= clr_done_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  // single write port shared between the clear engine and writeback
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wa;
    mem_wd = wd;
    if (clr_busy) begin
      mem_we = 1'b1;
      mem_wa = clr_ptr_q;
      mem_wd = '0;
    end else if (wr_acc) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra_i;
    logic [XLEN-1:0] rd_i;

    assign ra_i = ra[i*AW +: AW];

    always_comb begin
      if (ZERO_REG && (ra_i == '0)) begin
        rd_i = '0;
      end else if (BYPASS && wr_acc && (wa == ra_i)) begin
        rd_i = wd;
      end else begin
        rd_i = mem_q[ra_i];
      end
    end

    assign rd[i*XLEN +: XLEN] = rd_i;
  end

endmodule

// File: tb/tb_regfile_param_clr.sv
// tb/tb_regfile_param_clr.sv - self-checking bench for regfile_param_clr
// Instance a: 32x32, 2 ports, bypass; instance b: 16x64, 3 ports, no bypass.
module tb_regfile_param_clr;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_we, a_clr_req, a_busy, a_done, a_drop;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic [9:0]  a_ra;
  logic [63:0] a_rd;

  logic         b_rst_n, b_we, b_clr_req, b_busy, b_done, b_drop;
  logic [3:0]   b_wa;
  logic [63:0]  b_wd;
  logic [11:0]  b_ra;
  logic [191:0] b_rd;

  regfile_param_clr dut_a (
    .clk(clk), .reset_n(a_rst_n), .we(a_we), .wa(a_wa), .wd(a_wd), .ra(a_ra), .rd(a_rd),
    .clr_req(a_clr_req), .clr_busy(a_busy), .clr_done(a_done), .wr_drop(a_drop)
  );

  regfile_param_clr #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
    .clk(clk), .reset_n(b_rst_n), .we(b_we), .wa(b_wa), .wd(b_wd), .ra(b_ra), .rd(b_rd),
    .clr_req(b_clr_req), .clr_busy(b_busy), .clr_done(b_done), .wr_drop(b_drop)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  typedef struct packed {
    logic [31:0] e0;
    logic [31:0] e1;
  } exp_t;

  vec_t vecs [9];
  exp_t sb_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic a_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    a_we = 1'b1; a_wa = a; a_wd = d;
    @(posedge clk); #1;
    a_we = 1'b0;
  endtask

  task automatic a_read(input logic [4:0] r, input logic [31:0] exp, input string nm);
    a_ra = {r, r};
    #1;
    chk({nm, "_p0"}, a_rd[31:0], exp);
    chk({nm, "_p1"}, a_rd[63:32], exp);
  endtask

  // cycle c: inputs applied at posedge+1, outputs sampled at negedge
  task automatic a_clear_run(input int req_at, input int req2_at, input int wr_at, input int rst_at,
                             input logic [4:0] wr_a, output int busy_n, output int done_n,
                             output int drop_n);
    busy_n = 0; done_n = 0; drop_n = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      a_clr_req = (c == req_at) || (c == req2_at);
      a_we      = (c == wr_at);
      a_wa      = wr_a;
      a_wd      = 32'hCAFEF00D;
      @(negedge clk);
      if (a_busy) busy_n++;
      if (a_done) done_n++;
      if (a_drop) drop_n++;
      if (c == rst_at) begin
        #1 a_rst_n = 1'b0;
        #1 chk("busy_in_reset", a_busy, 1);
        #1 a_rst_n = 1'b1;
      end
    end
    a_clr_req = 1'b0;
    a_we      = 1'b0;
  endtask

  int   nb, nd, ndr, nb2, nd2;
  exp_t e;

  initial begin
    a_rst_n = 1'b0; a_we = 1'b0; a_wa = '0; a_wd = '0; a_ra = '0; a_clr_req = 1'b0;
    b_rst_n = 1'b0; b_we = 1'b0; b_wa = '0; b_wd = '0; b_ra = '0; b_clr_req = 1'b0;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[4] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd3,  32'hA5A5A5A5, 32'h0};
    vecs[5] = '{1'b1, 5'd3,  32'h11112222, 5'd3,  5'd7,  32'h11112222, 32'hA5A5A5A5};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd31, 32'h11112222, 32'h0};
    vecs[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd3,  32'hFFFFFFFF, 32'h11112222};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", a_busy, 1);
    chk("rst_done", a_done, 0);
    chk("rst_drop", a_drop, 0);
    chk("b_rst_busy", b_busy, 1);

    @(posedge clk); #1;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    nb = 0; nd = 0; nb2 = 0; nd2 = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (a_busy) nb++;
      if (a_done) nd++;
      if (b_busy) nb2++;
      if (b_done) nd2++;
    end
    chk("init_busy_cycles", nb, 32);
    chk("init_done_pulses", nd, 1);
    chk("b_init_busy_cycles", nb2, 16);
    chk("b_init_done_pulses", nd2, 1);

    for (int r = 0; r < 32; r++) a_read(5'(r), 32'h0, "init_zero");
    for (int r = 0; r < 16; r++) begin
      b_ra = {3{4'(r)}};
      #1;
      chk("b_init_zero", b_rd, 192'h0);
    end

    // table vectors through the scoreboard
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      a_we = vecs[i].we; a_wa = vecs[i].wa; a_wd = vecs[i].wd;
      a_ra = {vecs[i].ra1, vecs[i].ra0};
      sb_q.push_back('{vecs[i].e0, vecs[i].e1});
      @(negedge clk);
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("vec_rd0", a_rd[31:0], e.e0);
        chk("vec_rd1", a_rd[63:32], e.e1);
        chk("vec_drop", a_drop, 0);
        chk("vec_busy", a_busy, 0);
      end
    end
    @(posedge clk); #1;
    a_we = 1'b0;
    chk("sb_empty", sb_q.size(), 0);

    // clear request with a write dropped mid-clear (ptr 20, addr 3)
    a_clear_run(0, -1, 21, -1, 5'd3, nb, nd, ndr);
    chk("clr_busy_cycles", nb, 32);
    chk("clr_done_pulses", nd, 1);
    chk("clr_drop_pulses", ndr, 1);
    a_read(5'd3, 32'h0, "clr_x3");
    a_read(5'd7, 32'h0, "clr_x7");
    a_read(5'd31, 32'h0, "clr_x31");

    // restart at ptr 10
    a_clear_run(0, 11, -1, -1, 5'd0, nb, nd, ndr);
    chk("restart10_busy", nb, 43);
    chk("restart10_done", nd, 1);
    chk("restart10_drop", ndr, 0);

    // restart on the final clear step
    a_clear_run(0, 32, -1, -1, 5'd0, nb, nd, ndr);
    chk("restart_last_busy", nb, 64);
    chk("restart_last_done", nd, 1);

    // reset at ptr 20
    a_write(5'd4, 32'h44444444);
    a_read(5'd4, 32'h44444444, "pre_rst_x4");
    a_clear_run(0, -1, -1, 21, 5'd0, nb, nd, ndr);
    chk("rst20_busy", nb, 52);
    chk("rst20_done", nd, 1);
    a_read(5'd4, 32'h0, "rst20_x4");

    // reset during a write in IDLE
    a_write(5'd9, 32'h99999999);
    a_read(5'd9, 32'h99999999, "pre_rstw_x9");
    a_clear_run(-1, -1, 2, 2, 5'd9, nb, nd, ndr);
    chk("rstw_busy", nb, 31);
    chk("rstw_done", nd, 1);
    chk("rstw_drop", ndr, 1);
    a_read(5'd9, 32'h0, "rstw_x9");

    // 16x64 three-port instance, no bypass
    @(posedge clk); #1;
    b_we = 1'b1; b_wa = 4'd5; b_wd = 64'hDEADBEEF_01234567; b_ra = {4'd0, 4'd5, 4'd5};
    @(negedge clk);
    chk("b_nobypass_p0", b_rd[63:0], 64'h0);
    chk("b_nobypass_p1", b_rd[127:64], 64'h0);
    @(posedge clk); #1;
    b_wa = 4'd15; b_wd = 64'h01234567_89ABCDEF; b_ra = {4'd15, 4'd5, 4'd0};
    @(negedge clk);
    chk("b_v1_p0", b_rd[63:0], 64'h0);
    chk("b_v1_p1", b_rd[127:64], 64'hDEADBEEF_01234567);
    chk("b_v1_p2", b_rd[191:128], 64'h0);
    @(posedge clk); #1;
    b_wa = 4'd0; b_wd = 64'hFFFFFFFF_FFFFFFFF; b_ra = {4'd0, 4'd15, 4'd5};
    @(negedge clk);
    chk("b_v2", b_rd, {64'h0, 64'h01234567_89ABCDEF, 64'hDEADBEEF_01234567});
    @(posedge clk); #1;
    b_we = 1'b0; b_ra = {4'd5, 4'd0, 4'd15};
    @(negedge clk);
    chk("b_v3", b_rd, {64'hDEADBEEF_01234567, 64'h0, 64'h01234567_89ABCDEF});
    chk("b_v3_drop", b_drop, 0);

    @(posedge clk); #1;
    b_clr_req = 1'b1;
    @(posedge clk); #1;
    b_clr_req = 1'b0;
    nb = 0; nd = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (b_busy) nb++;
      if (b_done) nd++;
    end
    chk("b_clr_busy", nb, 16);
    chk("b_clr_done", nd, 1);
    b_ra = {4'd15, 4'd5, 4'd5};
    #1;
    chk("b_clr_zero", b_rd, 192'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
